// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - iterative ALU with one-bit-per-cycle shifter and valid/ready handshake
module alu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            zero_q, zero_d;

    logic [SW-1:0]   shamt;
    logic            is_shift;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_next;

    assign shamt    = b[SW-1:0];
    assign is_shift = (alu_control == 4'd7) || (alu_control == 4'd8) || (alu_control == 4'd9);

    always_comb begin
        alu_res = '0;
        case (alu_control)
            4'd0: alu_res = a + b;
            4'd1: alu_res = a - b;
            4'd2: alu_res = a & b;
            4'd3: alu_res = a | b;
            4'd4: alu_res = a ^ b;
            4'd5: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // Single-step shift of the working register, selected by the captured opcode
    always_comb begin
        shift_next = work_q;
        case (op_q)
            4'd7:    shift_next = {work_q[XLEN-2:0], 1'b0};
            4'd8:    shift_next = {1'b0, work_q[XLEN-1:1]};
            default: shift_next = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = alu_control;
                    if (is_shift && (shamt != '0)) begin
                        work_d  = a;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = is_shift ? a : alu_res;
                        zero_d   = ~|result_d;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shift_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    result_d = shift_next;
                    zero_d   = ~|shift_next;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A kill wins over any acceptance or completion on the same edge
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
